// File: rtl/alu_stage.sv
// alu_stage: execute stage of the 16-bit CPU, fed directly by the decoder.
//
// An accepted en captures the operands. Every op except a multi-bit shift
// produces a registered result with a one-cycle done pulse on the next cycle.
// Shifts by more than one bit run one bit per cycle in the SHIFT state; busy
// is high while they run, and en is ignored during that time.
//
// Build option:
//   ALU_BARREL_SHIFT_EN  - when defined, SHL/SHR finish in one cycle like any
//                          other op. SHIFT is never entered and busy stays 0.
//                          Results are identical in both builds.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   en            start pulse, accepted only when idle
//   alu_op        {opcode[3:0], F flag}
//   data_a/b      register operands; shift amount is data_b[$clog2(WIDTH)-1:0]
//   data_imm      immediate from decode
//   reg_d_we_in   write-enable from decode
//   result        registered result or branch target (holds between ops)
//   reg_d_we_out  write-back enable, high only with done
//   branch        branch request, high only with done
//   busy          iterative shift in progress
//   done          one-cycle pulse marking result/branch/reg_d_we_out valid
module alu_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_imm,
    input  logic             reg_d_we_in,
    output logic [WIDTH-1:0] result,
    output logic             reg_d_we_out,
    output logic             branch,
    output logic             busy,
    output logic             done
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_OR     = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_AND    = 4'b0100;
    localparam logic [3:0] OP_NOT    = 4'b0101;
    localparam logic [3:0] OP_READ   = 4'b0110;
    localparam logic [3:0] OP_WRITE  = 4'b0111;
    localparam logic [3:0] OP_LOAD   = 4'b1000;
    localparam logic [3:0] OP_CMP    = 4'b1001;
    localparam logic [3:0] OP_SHL    = 4'b1010;
    localparam logic [3:0] OP_SHR    = 4'b1011;
    localparam logic [3:0] OP_JUMP   = 4'b1100;
    localparam logic [3:0] OP_JUMPEQ = 4'b1101;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_next;
    logic [SH_W-1:0]   sh_cnt_p1;
    logic [WIDTH-1:0]  sh_val_p1;
    logic              sh_left_p1;
    logic              sh_we_p1;
    logic [WIDTH-1:0]  result_p1;
    logic              branch_p1;
    logic              we_p1;
    logic              vld_p1;

    logic [3:0]        opcode;
    logic              flag;
    logic [SH_W-1:0]   amt;
    logic              is_shift;
    logic              is_reserved;
    logic              accept;
    logic              iter_req;
    logic              shift_last;

    // Comparison flags; F selects signed or unsigned ordering.
    function automatic logic [WIDTH-1:0] cmp_flags(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic             sgn);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [WIDTH-1:0]        r;
        logic                    gt;
        logic                    lt;
        sa = $signed(a);
        sb = $signed(b);
        gt = sgn ? (sa > sb) : (a > b);
        lt = sgn ? (sa < sb) : (a < b);
        r = '0;
        r[WIDTH-1] = (a == b);
        r[WIDTH-2] = gt;
        r[WIDTH-3] = lt;
        r[WIDTH-4] = (a == '0);
        r[WIDTH-5] = (b == '0);
        return r;
    endfunction

    // Single-cycle result for every op; shifts use the full barrel form, which
    // the iterative build only reaches for amounts of 0 or 1.
    function automatic logic [WIDTH-1:0] alu_func(input logic [3:0]       op,
                                                  input logic             f,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] imm,
                                                  input logic [SH_W-1:0]  sh);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_ADD:    r = a + b;
            OP_SUB:    r = a - b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_AND:    r = a & b;
            OP_NOT:    r = ~a;
            OP_READ:   r = a;
            OP_WRITE:  r = a;
            OP_LOAD:   r = f ? {imm[WIDTH-1:WIDTH/2], {(WIDTH/2){1'b0}}}
                             : {{(WIDTH/2){1'b0}}, imm[WIDTH/2-1:0]};
            OP_CMP:    r = cmp_flags(a, b, f);
            OP_SHL:    r = a << sh;
            OP_SHR:    r = a >> sh;
            OP_JUMP:   r = f ? imm : a;
            OP_JUMPEQ: r = b;
            default:   r = '0;
        endcase
        return r;
    endfunction

    function automatic logic branch_of(input logic [3:0] op, input logic [WIDTH-1:0] a);
        // JUMPEQ reads the EQ bit left in a by an earlier CMP.
        return (op == OP_JUMP) || ((op == OP_JUMPEQ) && a[WIDTH-1]);
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v, input logic left);
        return left ? (v << 1) : (v >> 1);
    endfunction

    assign opcode      = alu_op[4:1];
    assign flag        = alu_op[0];
    assign amt         = data_b[SH_W-1:0];
    assign is_shift    = (opcode == OP_SHL) || (opcode == OP_SHR);
    assign is_reserved = (opcode[3:1] == 3'b111);
    assign accept      = en && (state == IDLE);
    assign shift_last  = (sh_cnt_p1 == SH_W'(1));

`ifdef ALU_BARREL_SHIFT_EN
    assign iter_req = 1'b0;
`else
    // Amounts 0 and 1 finish in the accept cycle; only longer shifts iterate.
    assign iter_req = is_shift && (amt > SH_W'(1));
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && iter_req) state_next = SHIFT;
            SHIFT:   if (shift_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---- p0 -> p1: control registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sh_cnt_p1 <= '0;
            result_p1 <= '0;
            branch_p1 <= 1'b0;
            we_p1     <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            state     <= state_next;
            vld_p1    <= 1'b0;
            branch_p1 <= 1'b0;
            we_p1     <= 1'b0;
            if (accept) begin
                if (iter_req) begin
                    // First bit is shifted in the accept cycle, so k-1 remain.
                    sh_cnt_p1 <= amt - SH_W'(1);
                end else begin
                    result_p1 <= alu_func(opcode, flag, data_a, data_b, data_imm, amt);
                    branch_p1 <= branch_of(opcode, data_a);
                    we_p1     <= reg_d_we_in && !is_reserved;
                    vld_p1    <= 1'b1;
                end
            end else if (state == SHIFT) begin
                if (shift_last) begin
                    result_p1 <= shift_one(sh_val_p1, sh_left_p1);
                    we_p1     <= sh_we_p1;
                    vld_p1    <= 1'b1;
                    sh_cnt_p1 <= '0;
                end else begin
                    sh_cnt_p1 <= sh_cnt_p1 - SH_W'(1);
                end
            end
        end
    end

    // ---- p0 -> p1: iterative shift datapath ----
    always_ff @(posedge clk) begin
        if (accept && iter_req) begin
            sh_val_p1  <= shift_one(data_a, opcode == OP_SHL);
            sh_left_p1 <= (opcode == OP_SHL);
            sh_we_p1   <= reg_d_we_in;
        end else if (state == SHIFT) begin
            sh_val_p1  <= shift_one(sh_val_p1, sh_left_p1);
        end
    end

    assign result       = result_p1;
    assign branch       = branch_p1;
    assign reg_d_we_out = we_p1;
    assign done         = vld_p1;
    assign busy         = (state == SHIFT);

endmodule

// File: tb/tb_alu_stage.sv
module tb_alu_stage;
    localparam int W = 16;

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, OR_ = 4'b0010, XOR_ = 4'b0011;
    localparam logic [3:0] AND_ = 4'b0100, NOT_ = 4'b0101, LOAD = 4'b1000, CMP = 4'b1001;
    localparam logic [3:0] SHL = 4'b1010, SHR = 4'b1011, JUMP = 4'b1100, JUMPEQ = 4'b1101;
    localparam logic [3:0] RSV0 = 4'b1110, RSV1 = 4'b1111;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [4:0]   alu_op;
    logic [W-1:0] data_a, data_b, data_imm;
    logic         reg_d_we_in;
    logic [W-1:0] result;
    logic         reg_d_we_out, branch, busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    alu_stage #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .alu_op       (alu_op),
        .data_a       (data_a),
        .data_b       (data_b),
        .data_imm     (data_imm),
        .reg_d_we_in  (reg_d_we_in),
        .result       (result),
        .reg_d_we_out (reg_d_we_out),
        .branch       (branch),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one en pulse from the current falling edge; returns at the next
    // falling edge, i.e. in cycle N+1.
    task automatic issue(input logic [3:0] op, input logic f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] imm, input logic we);
        alu_op = {op, f}; data_a = a; data_b = b; data_imm = imm; reg_d_we_in = we;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic chk_done(input string tag, input logic [W-1:0] res, input logic we, input logic br);
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".result"}, result, res);
        chk({tag, ".we"}, reg_d_we_out, we);
        chk({tag, ".branch"}, branch, br);
        chk({tag, ".busy"}, busy, 1'b0);
    endtask

    initial begin
        logic seen;
        reset = 1'b1; en = 1'b0; alu_op = '0; data_a = '0; data_b = '0;
        data_imm = '0; reg_d_we_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.result", result, 16'h0000);
        chk("rst.done", done, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.branch", branch, 1'b0);
        chk("rst.we", reg_d_we_out, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Arithmetic and logic
        issue(ADD, 1'b0, 16'hFFFF, 16'h0002, 16'h0000, 1'b1);
        chk_done("add", 16'h0001, 1'b1, 1'b0);
        @(negedge clk);
        chk("add.hold.done", done, 1'b0);
        chk("add.hold.result", result, 16'h0001);
        chk("add.hold.we", reg_d_we_out, 1'b0);

        issue(SUB, 1'b0, 16'h0001, 16'h0002, 16'h0000, 1'b1);
        chk_done("sub", 16'hFFFF, 1'b1, 1'b0);
        issue(OR_, 1'b0, 16'hF0F0, 16'hFF00, 16'h0000, 1'b1);
        chk_done("or", 16'hFFF0, 1'b1, 1'b0);
        issue(XOR_, 1'b0, 16'hF0F0, 16'hFF00, 16'h0000, 1'b1);
        chk_done("xor", 16'h0FF0, 1'b1, 1'b0);
        issue(AND_, 1'b0, 16'hF0F0, 16'hFF00, 16'h0000, 1'b0);
        chk_done("and", 16'hF000, 1'b0, 1'b0);
        issue(NOT_, 1'b0, 16'hF0F0, 16'hFF00, 16'h0000, 1'b1);
        chk_done("not", 16'h0F0F, 1'b1, 1'b0);

        // LOAD halves
        issue(LOAD, 1'b1, 16'h0000, 16'h0000, 16'hA5A5, 1'b1);
        chk_done("load.hi", 16'hA500, 1'b1, 1'b0);
        issue(LOAD, 1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b1);
        chk_done("load.lo", 16'h00A5, 1'b1, 1'b0);

        // CMP signed / unsigned / equal-and-zero
        issue(CMP, 1'b1, 16'h8000, 16'h0001, 16'h0000, 1'b1);
        chk_done("cmp.s", 16'h2000, 1'b1, 1'b0);
        issue(CMP, 1'b0, 16'h8000, 16'h0001, 16'h0000, 1'b1);
        chk_done("cmp.u", 16'h4000, 1'b1, 1'b0);
        issue(CMP, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        chk_done("cmp.eq0", 16'h9800, 1'b1, 1'b0);

        // Short shifts complete immediately in both builds
        issue(SHL, 1'b0, 16'h1234, 16'h0000, 16'h0000, 1'b1);
        chk_done("shl.k0", 16'h1234, 1'b1, 1'b0);
        issue(SHR, 1'b0, 16'h0004, 16'h0001, 16'h0000, 1'b1);
        chk_done("shr.k1", 16'h0002, 1'b1, 1'b0);

        // SHL by 5 with a second en arriving mid-shift
        issue(SHL, 1'b0, 16'h0003, 16'h0005, 16'h0000, 1'b1);
`ifdef ALU_BARREL_SHIFT_EN
        chk_done("shl5", 16'h0060, 1'b1, 1'b0);
        @(negedge clk);
        chk("shl5.after.done", done, 1'b0);
`else
        chk("shl5.n1.busy", busy, 1'b1);
        chk("shl5.n1.done", done, 1'b0);
        @(negedge clk);
        chk("shl5.n2.busy", busy, 1'b1);
        alu_op = {ADD, 1'b0}; data_a = 16'h0007; data_b = 16'h0007; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk("shl5.n3.busy", busy, 1'b1);
        chk("shl5.n3.done", done, 1'b0);
        @(negedge clk);
        chk("shl5.n4.busy", busy, 1'b1);
        chk("shl5.n4.result", result, 16'h0002);
        @(negedge clk);
        chk_done("shl5.n5", 16'h0060, 1'b1, 1'b0);
        @(negedge clk);
        chk("shl5.n6.done", done, 1'b0);
        chk("shl5.n6.busy", busy, 1'b0);
        chk("shl5.n6.result", result, 16'h0060);
`endif

        // Branches
        issue(JUMP, 1'b1, 16'h1111, 16'h2222, 16'h4242, 1'b0);
        chk_done("jump.imm", 16'h4242, 1'b0, 1'b1);
        @(negedge clk);
        chk("jump.hold.branch", branch, 1'b0);
        issue(JUMP, 1'b0, 16'h1234, 16'h2222, 16'h4242, 1'b0);
        chk_done("jump.a", 16'h1234, 1'b0, 1'b1);
        issue(JUMPEQ, 1'b0, 16'h8000, 16'h0010, 16'h0000, 1'b0);
        chk_done("jeq.t", 16'h0010, 1'b0, 1'b1);
        issue(JUMPEQ, 1'b0, 16'h0000, 16'h0010, 16'h0000, 1'b0);
        chk_done("jeq.nt", 16'h0010, 1'b0, 1'b0);

        // Reserved opcodes
        issue(RSV0, 1'b0, 16'h1234, 16'h5678, 16'h9ABC, 1'b1);
        chk_done("rsv0", 16'h0000, 1'b0, 1'b0);
        issue(RSV1, 1'b1, 16'h1234, 16'h5678, 16'h9ABC, 1'b1);
        chk_done("rsv1", 16'h0000, 1'b0, 1'b0);

        // Reset in the middle of a 10-bit SHR
        issue(ADD, 1'b0, 16'h0001, 16'h0001, 16'h0000, 1'b1);
        issue(SHR, 1'b0, 16'h8000, 16'h000A, 16'h0000, 1'b1);
`ifdef ALU_BARREL_SHIFT_EN
        chk_done("shr10", 16'h0020, 1'b1, 1'b0);
`else
        chk("shr10.n1.busy", busy, 1'b1);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid.busy", busy, 1'b0);
        chk("rstmid.done", done, 1'b0);
        chk("rstmid.result", result, 16'h0000);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        chk("rstmid.no_done", seen, 1'b0);
        chk("rstmid.result.hold", result, 16'h0000);

        // Normal op after the abort
        issue(ADD, 1'b0, 16'h0100, 16'h0023, 16'h0000, 1'b1);
        chk_done("post_rst.add", 16'h0123, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
